// File: rtl/dccm_arb.sv
// Two-port (LSU/DMA) arbiter in front of a single-ported DCCM.
// LSU has priority; a saturating counter forces a DMA win after STARVE_LIMIT denied cycles.
module dccm_arb #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_gnt,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_rvalid,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [XLEN-1:0] dma_addr,
  input  logic [XLEN-1:0] dma_wdata,
  output logic            dma_gnt,
  output logic [XLEN-1:0] dma_rdata,
  output logic            dma_rvalid,
  output logic [XLEN-1:0] mem_raddr,
  output logic            mem_rvalid_in,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid_out,
  output logic [XLEN-1:0] mem_waddr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      starve_cnt,
  output logic            err_spurious
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;
  logic       r_pend;
  logic       r_owner;
  logic       r_err;

  logic            w_lsu_win;
  logic            w_dma_win;
  logic            w_any;
  logic            w_we;
  logic            w_resp;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;

  // Grant selection: a starved DMA overrides the default LSU priority
  always_comb begin
    w_lsu_win = 1'b0;
    w_dma_win = 1'b0;
    if (rst) begin
      w_lsu_win = 1'b0;
    end else if (dma_req && (r_starve == LIMIT)) begin
      w_dma_win = 1'b1;
    end else if (lsu_req) begin
      w_lsu_win = 1'b1;
    end else if (dma_req) begin
      w_dma_win = 1'b1;
    end else begin
      w_dma_win = 1'b0;
    end
  end

  assign w_any   = w_lsu_win | w_dma_win;
  assign w_we    = w_dma_win ? dma_we    : lsu_we;
  assign w_addr  = w_dma_win ? dma_addr  : lsu_addr;
  assign w_wdata = w_dma_win ? dma_wdata : lsu_wdata;

  assign lsu_gnt = w_lsu_win;
  assign dma_gnt = w_dma_win;

  // Exactly one DCCM operation per cycle; idle buses are held at zero
  assign mem_wen       = w_any & w_we;
  assign mem_rvalid_in = w_any & ~w_we;
  assign mem_waddr     = mem_wen       ? w_addr  : '0;
  assign mem_wdata     = mem_wen       ? w_wdata : '0;
  assign mem_raddr     = mem_rvalid_in ? w_addr  : '0;

  // A response is only forwarded when a read is outstanding
  assign w_resp     = mem_rvalid_out & r_pend & ~rst;
  assign lsu_rvalid = w_resp & ~r_owner;
  assign dma_rvalid = w_resp &  r_owner;
  assign lsu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

  assign starve_cnt   = r_starve;
  assign err_spurious = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= 4'd0;
      r_pend   <= 1'b0;
      r_owner  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (dma_req && !w_dma_win) begin
        if (r_starve != LIMIT) begin
          r_starve <= r_starve + 4'd1;
        end
      end else begin
        r_starve <= 4'd0;
      end
      r_pend <= mem_rvalid_in;
      if (mem_rvalid_in) begin
        r_owner <= w_dma_win;
      end
      if (mem_rvalid_out && !r_pend) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dccm_arb.sv
// Directed testbench for dccm_arb: inputs change 1 time unit after the rising
// edge, outputs are sampled 3 time units later, well away from either edge.
module tb_dccm_arb;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            lsu_req, lsu_we, dma_req, dma_we;
  logic [XLEN-1:0] lsu_addr, lsu_wdata, dma_addr, dma_wdata;
  logic            lsu_gnt, dma_gnt, lsu_rvalid, dma_rvalid;
  logic [XLEN-1:0] lsu_rdata, dma_rdata;
  logic [XLEN-1:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic            mem_rvalid_in, mem_rvalid_out, mem_wen;
  logic [3:0]      starve_cnt;
  logic            err_spurious;

  int n_checks = 0;
  int n_fail   = 0;

  dccm_arb #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_raddr(mem_raddr), .mem_rvalid_in(mem_rvalid_in),
    .mem_rdata(mem_rdata), .mem_rvalid_out(mem_rvalid_out),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .starve_cnt(starve_cnt), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0; mem_rvalid_out = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    lsu_req = 1'b1; dma_req = 1'b1;
    tick();
    #3;
    n_checks++; if (lsu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt lsu=%b dma=%b expected 0 0", lsu_gnt, dma_gnt); end
    n_checks++; if (mem_wen !== 1'b0 || mem_rvalid_in !== 1'b0) begin n_fail++; $display("FAIL reset_mem wen=%b rvin=%b expected 0 0", mem_wen, mem_rvalid_in); end
    n_checks++; if (lsu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid lsu=%b dma=%b expected 0 0", lsu_rvalid, dma_rvalid); end
    n_checks++; if (starve_cnt !== 4'd0 || err_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_state starve=%0d err=%b expected 0 0", starve_cnt, err_spurious); end
    idle_inputs();
    tick();
    rst = 1'b0;
    #3;
    n_checks++; if (mem_wen !== 1'b0 || mem_rvalid_in !== 1'b0 || mem_raddr !== 32'h0 || mem_waddr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL idle_mem wen=%b rvin=%b raddr=%h waddr=%h wdata=%h expected all 0", mem_wen, mem_rvalid_in, mem_raddr, mem_waddr, mem_wdata); end
  endtask

  task automatic test_lsu_read();
    tick();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h40;
    #3;
    n_checks++; if (lsu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin n_fail++; $display("FAIL lsu_read_gnt lsu=%b dma=%b expected 1 0", lsu_gnt, dma_gnt); end
    n_checks++; if (mem_rvalid_in !== 1'b1 || mem_raddr !== 32'h40 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL lsu_read_issue rvin=%b raddr=%h wen=%b expected 1 00000040 0", mem_rvalid_in, mem_raddr, mem_wen); end
    tick();
    idle_inputs();
    mem_rvalid_out = 1'b1; mem_rdata = 32'hDEADBEEF;
    #3;
    n_checks++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lsu_read_resp rvalid=%b rdata=%h expected 1 deadbeef", lsu_rvalid, lsu_rdata); end
    n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL lsu_read_dma_quiet dma_rvalid=%b expected 0", dma_rvalid); end
    tick();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic exp_dma;
    tick();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'hA0; lsu_wdata = 32'h1111;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'hB0; dma_wdata = 32'h2222;
    for (int i = 0; i < 10; i++) begin
      exp_dma = ((i % 5) == 4);
      #3;
      n_checks++; if (dma_gnt !== exp_dma || lsu_gnt !== !exp_dma) begin n_fail++; $display("FAIL starve_gnt cycle %0d lsu=%b dma=%b expected %b %b", i, lsu_gnt, dma_gnt, !exp_dma, exp_dma); end
      n_checks++; if (starve_cnt !== 4'(i % 5)) begin n_fail++; $display("FAIL starve_cnt cycle %0d got %0d expected %0d", i, starve_cnt, i % 5); end
      n_checks++; if (mem_waddr !== (exp_dma ? 32'hB0 : 32'hA0) || mem_wen !== 1'b1) begin n_fail++; $display("FAIL starve_waddr cycle %0d got %h wen=%b expected %h 1", i, mem_waddr, mem_wen, exp_dma ? 32'hB0 : 32'hA0); end
      tick();
    end
    idle_inputs();
    #3;
    n_checks++; if (starve_cnt !== 4'd0) begin n_fail++; $display("FAIL starve_after got %0d expected 0", starve_cnt); end
  endtask

  task automatic test_back_to_back();
    tick();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h10;
    #3;
    n_checks++; if (lsu_gnt !== 1'b1 || mem_raddr !== 32'h10) begin n_fail++; $display("FAIL b2b_lsu_issue gnt=%b raddr=%h expected 1 00000010", lsu_gnt, mem_raddr); end
    tick();
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    mem_rvalid_out = 1'b1; mem_rdata = 32'hAAAA1111;
    #3;
    n_checks++; if (dma_gnt !== 1'b1 || mem_raddr !== 32'h20 || mem_rvalid_in !== 1'b1) begin n_fail++; $display("FAIL b2b_dma_issue gnt=%b raddr=%h rvin=%b expected 1 00000020 1", dma_gnt, mem_raddr, mem_rvalid_in); end
    n_checks++; if (lsu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || lsu_rdata !== 32'hAAAA1111) begin n_fail++; $display("FAIL b2b_lsu_resp lsu=%b dma=%b rdata=%h expected 1 0 aaaa1111", lsu_rvalid, dma_rvalid, lsu_rdata); end
    tick();
    idle_inputs();
    mem_rvalid_out = 1'b1; mem_rdata = 32'hBBBB2222;
    #3;
    n_checks++; if (dma_rvalid !== 1'b1 || lsu_rvalid !== 1'b0 || dma_rdata !== 32'hBBBB2222) begin n_fail++; $display("FAIL b2b_dma_resp dma=%b lsu=%b rdata=%h expected 1 0 bbbb2222", dma_rvalid, lsu_rvalid, dma_rdata); end
    tick();
    idle_inputs();
    #3;
    n_checks++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL b2b_no_err err=%b expected 0", err_spurious); end
  endtask

  task automatic test_dma_write();
    tick();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'h12345678;
    #3;
    n_checks++; if (dma_gnt !== 1'b1 || lsu_gnt !== 1'b0) begin n_fail++; $display("FAIL dma_write_gnt dma=%b lsu=%b expected 1 0", dma_gnt, lsu_gnt); end
    n_checks++; if (mem_wen !== 1'b1 || mem_waddr !== 32'h100 || mem_wdata !== 32'h12345678 || mem_rvalid_in !== 1'b0) begin n_fail++; $display("FAIL dma_write_issue wen=%b waddr=%h wdata=%h rvin=%b expected 1 00000100 12345678 0", mem_wen, mem_waddr, mem_wdata, mem_rvalid_in); end
    tick();
    idle_inputs();
    mem_rdata = 32'h5A5A5A5A;
    #3;
    n_checks++; if (lsu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dma_write_no_resp lsu=%b dma=%b expected 0 0", lsu_rvalid, dma_rvalid); end
  endtask

  task automatic test_spurious();
    tick();
    mem_rvalid_out = 1'b1; mem_rdata = 32'hCAFEF00D;
    #3;
    n_checks++; if (lsu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL spurious_dropped lsu=%b dma=%b expected 0 0", lsu_rvalid, dma_rvalid); end
    tick();
    idle_inputs();
    #3;
    n_checks++; if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL spurious_set err=%b expected 1", err_spurious); end
    tick(); tick(); tick();
    #3;
    n_checks++; if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL spurious_sticky err=%b expected 1", err_spurious); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3;
    n_checks++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL spurious_clear err=%b expected 0", err_spurious); end
  endtask

  task automatic test_reset_mid_read();
    tick();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h80;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h90;
    #3;
    n_checks++; if (lsu_gnt !== 1'b1 || mem_rvalid_in !== 1'b1) begin n_fail++; $display("FAIL midrst_issue gnt=%b rvin=%b expected 1 1", lsu_gnt, mem_rvalid_in); end
    tick();
    idle_inputs();
    rst = 1'b1; dma_req = 1'b1;
    mem_rvalid_out = 1'b1; mem_rdata = 32'h77777777;
    #3;
    n_checks++; if (lsu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid lsu=%b dma=%b expected 0 0", lsu_rvalid, dma_rvalid); end
    n_checks++; if (lsu_gnt !== 1'b0 || dma_gnt !== 1'b0 || mem_wen !== 1'b0 || mem_rvalid_in !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs lsu_gnt=%b dma_gnt=%b wen=%b rvin=%b expected 0 0 0 0", lsu_gnt, dma_gnt, mem_wen, mem_rvalid_in); end
    tick();
    idle_inputs();
    rst = 1'b0;
    mem_rdata = 32'h77777777;
    #3;
    n_checks++; if (lsu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_after lsu=%b dma=%b expected 0 0", lsu_rvalid, dma_rvalid); end
    n_checks++; if (starve_cnt !== 4'd0 || err_spurious !== 1'b0) begin n_fail++; $display("FAIL midrst_state starve=%0d err=%b expected 0 0", starve_cnt, err_spurious); end
  endtask

  initial begin
    test_reset();
    test_lsu_read();
    test_starvation();
    test_back_to_back();
    test_dma_write();
    test_spurious();
    test_reset_mid_read();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
